// File: rtl/gpio_pkg.sv
// Shared types and default widths for the GPIO input conditioner.
package gpio_pkg;

    localparam int unsigned GPIO_NPIN    = 32;
    localparam int unsigned GPIO_PRESC_W = 16;
    localparam int unsigned GPIO_CNT_W   = 8;

    typedef logic [GPIO_NPIN-1:0] gpio_vec_t;

endpackage

// File: rtl/gpio_deb_cell.sv
// One pin's debounce state: stability counter, filtered level and change pulse.
module gpio_deb_cell
    import gpio_pkg::*;
#(
    parameter int unsigned CNT_W = GPIO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1,
    input  logic             tick,
    input  logic             en,
    input  logic [CNT_W-1:0] thresh,
    output logic             filt,
    output logic             chg
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             chg_q;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   thr_eff;

    // Compare at CNT_W+1 bits so cnt+1 never wraps; a zero threshold acts as one.
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign thr_eff = (thresh == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, thresh};

    // Next-state: bypass, restart on old level, qualify on ticks, else hold.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (!en) begin
            filt_d = s1;
            cnt_d  = '0;
        end else if (s1 == filt_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_inc >= thr_eff) begin
                filt_d = s1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    // Pin state registers; chg pulses for the cycle after filt changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            chg_q  <= filt_d ^ filt_q;
        end
    end

    assign filt = filt_q;
    assign chg  = chg_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Pad input conditioner: 2-flop sync, shared tick prescaler, per-pin debounce cells.
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned NPIN    = GPIO_NPIN,
    parameter int unsigned PRESC_W = GPIO_PRESC_W,
    parameter int unsigned CNT_W   = GPIO_CNT_W
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NPIN-1:0]    pad_in,
    input  logic [NPIN-1:0]    cfg_en,
    input  logic [PRESC_W-1:0] cfg_presc,
    input  logic [CNT_W-1:0]   cfg_thresh,
    output logic [NPIN-1:0]    filt_out,
    output logic [NPIN-1:0]    filt_chg,
    output logic               tick
);

    logic [NPIN-1:0]    s0_q, s1_q;
    logic [PRESC_W-1:0] pcnt_q;
    logic               tick_q;

    // Two-flop synchroniser for the asynchronous pads.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= pad_in;
            s1_q <= s0_q;
        end
    end

    // Prescaler; >= lets a lowered cfg_presc take effect immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else if (pcnt_q >= cfg_presc) begin
            pcnt_q <= '0;
            tick_q <= 1'b1;
        end else begin
            pcnt_q <= pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        gpio_deb_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk    (HCLK),
            .rst    (HRESET),
            .s1     (s1_q[i]),
            .tick   (tick_q),
            .en     (cfg_en[i]),
            .thresh (cfg_thresh),
            .filt   (filt_out[i]),
            .chg    (filt_chg[i])
        );
    end

endmodule
